// File: rtl/hash_table_arb_pkg.sv
// Shared encodings for the hash table arbiter: table operations, response
// status codes and the arbiter FSM states.
package hash_table_arb_pkg;

    typedef enum logic [1:0] {
        OP_READ   = 2'b00,
        OP_WRITE  = 2'b01,
        OP_DELETE = 2'b10,
        OP_RSVD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        STATUS_OK    = 2'b00,
        STATUS_MISS  = 2'b01,
        STATUS_FULL  = 2'b10,
        STATUS_ERROR = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_e;

endpackage

// File: rtl/hash_table_arbiter_rr_arbiter.sv
// Round-robin grant: searches the request vector starting one past the
// supplied pointer (the last granted index) and returns a one-hot grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Offsets 1..NUM_REQ visit every index once, ending on the pointer itself.
    always_comb begin
        grant    = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand     = (int'(ptr) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!any && req[cand_idx]) begin
                any             = 1'b1;
                grant[cand_idx] = 1'b1;
                idx             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/hash_table_arbiter.sv
// Arbitrates several requesters onto a single-ported hash table, keeping one
// table operation in flight and returning a status/value to the granted requester.
module hash_table_arbiter
    import hash_table_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [2*NUM_REQ-1:0]           req_op,
    input  logic [KEY_WIDTH*NUM_REQ-1:0]   req_key,
    input  logic [VALUE_WIDTH*NUM_REQ-1:0] req_value,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [1:0]                     rsp_status,
    output logic [VALUE_WIDTH-1:0]         rsp_value,
    output logic                           busy,
    output logic                           ht_wr_en,
    output logic                           ht_rd_en,
    output logic                           ht_del_en,
    output logic [KEY_WIDTH-1:0]           ht_wr_key,
    output logic [KEY_WIDTH-1:0]           ht_rd_key,
    output logic [KEY_WIDTH-1:0]           ht_del_key,
    output logic [VALUE_WIDTH-1:0]         ht_wr_value,
    input  logic                           ht_wr_done,
    input  logic                           ht_wr_collision,
    input  logic                           ht_rd_valid,
    input  logic                           ht_rd_miss,
    input  logic                           ht_del_done,
    input  logic [VALUE_WIDTH-1:0]         ht_rd_value
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e                 state;
    state_e                 next_state;
    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       idx_q;
    op_e                    op_q;
    logic [KEY_WIDTH-1:0]   key_q;
    logic [VALUE_WIDTH-1:0] val_q;
    status_e                status_q;
    logic [VALUE_WIDTH-1:0] rdata_q;
    logic [CNT_W-1:0]       cnt;

    logic [NUM_REQ-1:0]     grant;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_any;
    logic [1:0]             sel_op;
    logic [KEY_WIDTH-1:0]   sel_key;
    logic [VALUE_WIDTH-1:0] sel_val;

    logic                   done;
    status_e                done_status;
    logic [VALUE_WIDTH-1:0] done_value;
    logic                   wait_timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    // Pick the granted requester's op/key/value out of the packed buses.
    always_comb begin
        sel_op  = '0;
        sel_key = '0;
        sel_val = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_op  = req_op[2*i +: 2];
                sel_key = req_key[KEY_WIDTH*i +: KEY_WIDTH];
                sel_val = req_value[VALUE_WIDTH*i +: VALUE_WIDTH];
            end
        end
    end

    // Only the strobes belonging to the latched op can complete it.
    always_comb begin
        done        = 1'b0;
        done_status = STATUS_OK;
        done_value  = '0;
        case (op_q)
            OP_READ: begin
                if (ht_rd_valid) begin
                    done       = 1'b1;
                    done_value = ht_rd_value;
                end else if (ht_rd_miss) begin
                    done        = 1'b1;
                    done_status = STATUS_MISS;
                end
            end
            OP_WRITE: begin
                if (ht_wr_done) begin
                    done = 1'b1;
                end else if (ht_wr_collision) begin
                    done        = 1'b1;
                    done_status = STATUS_FULL;
                end
            end
            OP_DELETE: done = ht_del_done;
            default:   done = 1'b0;
        endcase
    end

    assign wait_timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= IDX_W'(NUM_REQ - 1);
            idx_q    <= '0;
            op_q     <= OP_READ;
            key_q    <= '0;
            val_q    <= '0;
            status_q <= STATUS_OK;
            rdata_q  <= '0;
            cnt      <= '0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        ptr      <= grant_idx;
                        idx_q    <= grant_idx;
                        op_q     <= op_e'(sel_op);
                        key_q    <= sel_key;
                        val_q    <= sel_val;
                        status_q <= STATUS_ERROR;
                        rdata_q  <= '0;
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (done) begin
                        status_q <= done_status;
                        rdata_q  <= done_value;
                    end else if (wait_timeout) begin
                        status_q <= STATUS_ERROR;
                        rdata_q  <= '0;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

    // Reserved ops skip the table and answer ERROR straight away.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        ht_wr_en   = 1'b0;
        ht_rd_en   = 1'b0;
        ht_del_en  = 1'b0;
        rsp_valid  = '0;
        rsp_status = 2'b00;
        rsp_value  = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_any && !rst) begin
                    req_ready  = grant;
                    next_state = (op_e'(sel_op) == OP_RSVD) ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                ht_wr_en   = (op_q == OP_WRITE);
                ht_rd_en   = (op_q == OP_READ);
                ht_del_en  = (op_q == OP_DELETE);
                next_state = WAIT;
            end
            WAIT: begin
                if (done || wait_timeout) next_state = RESP;
            end
            RESP: begin
                rsp_valid  = NUM_REQ'(1) << idx_q;
                rsp_status = status_q;
                rsp_value  = rdata_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign ht_wr_key   = key_q;
    assign ht_rd_key   = key_q;
    assign ht_del_key  = key_q;
    assign ht_wr_value = val_q;

endmodule

// File: tb/tb_hash_table_arbiter.sv
// Self-checking bench for hash_table_arbiter: vector table plus hand-written
// sequences, with responses matched against a scoreboard queue.
module tb_hash_table_arbiter;
    import hash_table_arb_pkg::*;

    localparam int N  = 4;
    localparam int KW = 32;
    localparam int VW = 32;
    localparam int TO = 16;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [2*N-1:0]  req_op;
    logic [KW*N-1:0] req_key;
    logic [VW*N-1:0] req_value;
    logic [N-1:0]    rsp_valid;
    logic [1:0]      rsp_status;
    logic [VW-1:0]   rsp_value;
    logic            busy;
    logic            ht_wr_en, ht_rd_en, ht_del_en;
    logic [KW-1:0]   ht_wr_key, ht_rd_key, ht_del_key;
    logic [VW-1:0]   ht_wr_value;
    logic            ht_wr_done, ht_wr_collision, ht_rd_valid, ht_rd_miss, ht_del_done;
    logic [VW-1:0]   ht_rd_value;

    hash_table_arbiter #(
        .NUM_REQ        (N),
        .KEY_WIDTH      (KW),
        .VALUE_WIDTH    (VW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_key         (req_key),
        .req_value       (req_value),
        .rsp_valid       (rsp_valid),
        .rsp_status      (rsp_status),
        .rsp_value       (rsp_value),
        .busy            (busy),
        .ht_wr_en        (ht_wr_en),
        .ht_rd_en        (ht_rd_en),
        .ht_del_en       (ht_del_en),
        .ht_wr_key       (ht_wr_key),
        .ht_rd_key       (ht_rd_key),
        .ht_del_key      (ht_del_key),
        .ht_wr_value     (ht_wr_value),
        .ht_wr_done      (ht_wr_done),
        .ht_wr_collision (ht_wr_collision),
        .ht_rd_valid     (ht_rd_valid),
        .ht_rd_miss      (ht_rd_miss),
        .ht_del_done     (ht_del_done),
        .ht_rd_value     (ht_rd_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {K_NONE, K_RD_VALID, K_RD_MISS, K_WR_DONE, K_WR_COL, K_WR_BOTH, K_DEL_DONE} kind_e;

    typedef struct {
        int          req;
        logic [1:0]  op;
        logic [31:0] key;
        logic [31:0] value;
        kind_e       kind;
        logic [31:0] rd_data;
        logic [1:0]  exp_status;
        logic [31:0] exp_value;
    } vec_t;

    typedef struct {
        int          idx;
        logic [1:0]  status;
        logic [31:0] value;
    } sb_t;

    sb_t  sb[$];
    int   passed = 0;
    int   total  = 0;
    vec_t vecs[7];

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected)
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
        else
            passed++;
    endtask

    function automatic logic [2:0] exp_en(input logic [1:0] op);
        case (op)
            2'b00:   return 3'b010;
            2'b01:   return 3'b100;
            2'b10:   return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic drive_strobes(input kind_e k, input logic [31:0] d);
        ht_rd_valid     = (k == K_RD_VALID);
        ht_rd_miss      = (k == K_RD_MISS);
        ht_wr_done      = (k == K_WR_DONE) || (k == K_WR_BOTH);
        ht_wr_collision = (k == K_WR_COL) || (k == K_WR_BOTH);
        ht_del_done     = (k == K_DEL_DONE);
        ht_rd_value     = d;
    endtask

    task automatic set_lane(input int r, input logic [1:0] op, input logic [31:0] key, input logic [31:0] value);
        req_op[2*r +: 2]     = op;
        req_key[KW*r +: KW]  = key;
        req_value[VW*r +: VW] = value;
    endtask

    // One full best-case transaction: grant T, enable T+1, response T+2, rsp T+3.
    task automatic apply_stimulus(input logic [N-1:0] mask, input logic [N-1:0] hold, input vec_t v);
        @(negedge clk);
        set_lane(v.req, v.op, v.key, v.value);
        req_valid = mask;
        #1;
        check_output("grant", req_ready, onehot(v.req));
        sb.push_back('{v.req, v.exp_status, v.exp_value});
        @(negedge clk);
        req_valid = hold;
        #1;
        check_output("table_en", {ht_wr_en, ht_rd_en, ht_del_en}, exp_en(v.op));
        check_output("table_key", ht_rd_key, v.key);
        if (v.op == OP_WRITE) check_output("table_wr_value", ht_wr_value, v.value);
        check_output("busy_issue", busy, 1'b1);
        @(negedge clk);
        drive_strobes(v.kind, v.rd_data);
        @(negedge clk);
        drive_strobes(K_NONE, '0);
        #1;
        check_output("rsp_latency", rsp_valid, onehot(v.req));
    endtask

    // Scoreboard side: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid != '0) begin
            check_output("rsp_expected", sb.size() > 0, 1'b1);
            if (sb.size() > 0) begin
                sb_t e;
                e = sb.pop_front();
                check_output("rsp_onehot", rsp_valid, onehot(e.idx));
                check_output("rsp_status", rsp_status, e.status);
                check_output("rsp_value", rsp_value, e.value);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int got;
        vecs[0] = '{0, OP_WRITE,  32'h11,   32'hAA, K_WR_DONE,  32'h0,        STATUS_OK,   32'h0};
        vecs[1] = '{2, OP_READ,   32'h55,   32'h0,  K_RD_MISS,  32'h9999,     STATUS_MISS, 32'h0};
        vecs[2] = '{2, OP_READ,   32'h55,   32'h0,  K_RD_VALID, 32'h1234,     STATUS_OK,   32'h1234};
        vecs[3] = '{1, OP_WRITE,  32'h21,   32'hB1, K_WR_COL,   32'h0,        STATUS_FULL, 32'h0};
        vecs[4] = '{1, OP_WRITE,  32'h22,   32'hB2, K_WR_BOTH,  32'h0,        STATUS_OK,   32'h0};
        vecs[5] = '{1, OP_DELETE, 32'h22,   32'h0,  K_DEL_DONE, 32'h0,        STATUS_OK,   32'h0};
        vecs[6] = '{3, OP_READ,   32'h3333, 32'h0,  K_RD_VALID, 32'hDEADBEEF, STATUS_OK,   32'hDEADBEEF};

        rst       = 1'b1;
        req_valid = '1;
        req_op    = '0;
        req_key   = '0;
        req_value = '0;
        drive_strobes(K_NONE, '0);
        repeat (3) @(negedge clk);
        check_output("reset_req_ready", req_ready, '0);
        check_output("reset_busy", busy, 1'b0);
        check_output("reset_rsp", {rsp_valid, rsp_status, rsp_value}, '0);
        check_output("reset_table", {ht_wr_en, ht_rd_en, ht_del_en, ht_wr_key, ht_wr_value}, '0);
        req_valid = '0;
        rst       = 1'b0;

        foreach (vecs[i]) apply_stimulus(onehot(vecs[i].req), '0, vecs[i]);

        // Last grant was index 3, so contention must rotate 0,1,2,3,0.
        for (int i = 0; i < N; i++) set_lane(i, OP_READ, 32'h100 + i, '0);
        for (int k = 0; k < 5; k++) begin
            vec_t v;
            v = '{k % N, OP_READ, 32'h100 + (k % N), 32'h0, K_RD_VALID, 32'h2000 + k, STATUS_OK, 32'h2000 + k};
            apply_stimulus('1, '1, v);
        end
        req_valid = '0;

        // Delete with no completion; unrelated strobes must not finish it.
        @(negedge clk);
        set_lane(1, OP_DELETE, 32'h77, '0);
        req_valid = 4'b0010;
        #1;
        check_output("del_grant", req_ready, 4'b0010);
        sb.push_back('{1, STATUS_ERROR, 32'h0});
        @(negedge clk);
        req_valid = '0;
        #1;
        check_output("del_en", {ht_wr_en, ht_rd_en, ht_del_en}, 3'b001);
        got = -1;
        for (int k = 0; k < TO + 8 && got < 0; k++) begin
            @(negedge clk);
            #1;
            if (rsp_valid != '0) got = k;
            else drive_strobes((k % 2 == 0) ? K_RD_VALID : K_WR_BOTH, 32'hFFFF);
        end
        drive_strobes(K_NONE, '0);
        check_output("timeout_latency", got, TO);

        // Reserved op answers ERROR one cycle later without touching the table.
        @(negedge clk);
        set_lane(2, OP_RSVD, 32'h88, 32'h1);
        req_valid = 4'b0100;
        #1;
        check_output("rsvd_grant", req_ready, 4'b0100);
        sb.push_back('{2, STATUS_ERROR, 32'h0});
        @(negedge clk);
        req_valid = '0;
        #1;
        check_output("rsvd_rsp", rsp_valid, 4'b0100);
        check_output("rsvd_no_en", {ht_wr_en, ht_rd_en, ht_del_en}, 3'b000);

        // Reset during WAIT: abandoned, late strobe ignored, pointer back to 0.
        @(negedge clk);
        set_lane(1, OP_READ, 32'h99, '0);
        req_valid = 4'b0010;
        #1;
        check_output("rst_grant", req_ready, 4'b0010);
        @(negedge clk);
        req_valid = '0;
        #1;
        check_output("rst_issue_en", {ht_wr_en, ht_rd_en, ht_del_en}, 3'b010);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_rsp", rsp_valid, '0);
        @(negedge clk);
        rst = 1'b0;
        drive_strobes(K_RD_VALID, 32'h5A5A);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check_output("late_strobe_rsp", rsp_valid, '0);
            check_output("late_strobe_busy", busy, 1'b0);
        end
        drive_strobes(K_NONE, '0);
        apply_stimulus('1, '0, '{0, OP_READ, 32'h5, 32'h0, K_RD_VALID, 32'h42, STATUS_OK, 32'h42});

        @(negedge clk);
        check_output("scoreboard_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/hash_table_arbiter.md
HASH_TABLE_ARBITER -- requirements
Module: hash_table_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters (2..16).
REQ-002 SHALL have parameter KEY_WIDTH, default 32, and VALUE_WIDTH, default 32: key/value widths, matching the hash table.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum wait for a table response.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: req_valid  in  NUM_REQ  request pending; req_ready  out  NUM_REQ  one-hot accept pulse.
REQ-006 SHALL have ports: req_op  in  2*NUM_REQ  per-requester op (00 read, 01 write, 10 delete, 11 reserved); req_key  in  KEY_WIDTH*NUM_REQ; req_value  in  VALUE_WIDTH*NUM_REQ.
REQ-007 SHALL have ports: rsp_valid  out  NUM_REQ  one-hot response pulse; rsp_status  out  2  (00 OK, 01 MISS, 10 FULL, 11 ERROR); rsp_value  out  VALUE_WIDTH  read data; busy  out  1  operation in flight.
REQ-008 SHALL have table-side ports: ht_wr_en, ht_rd_en, ht_del_en  out  1; ht_wr_key, ht_rd_key, ht_del_key  out  KEY_WIDTH; ht_wr_value  out  VALUE_WIDTH.
REQ-009 SHALL have table-side inputs: ht_wr_done, ht_wr_collision, ht_rd_valid, ht_rd_miss, ht_del_done  in  1; ht_rd_value  in  VALUE_WIDTH.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; exactly one table operation in flight at any time.
REQ-011 IDLE: if any req_valid is set, SHALL grant one requester by round-robin, pulse its req_ready for that cycle, latch op/key/value/grant index, and go to ISSUE; reserved op (11) goes directly to RESP with status ERROR.
REQ-012 Round-robin SHALL start the search at (last granted index + 1) mod NUM_REQ; after reset the search starts at index 0.
REQ-013 ISSUE: SHALL assert exactly one of ht_wr_en/ht_rd_en/ht_del_en for exactly one cycle, with the latched key/value, then go to WAIT.
REQ-014 WAIT: completion SHALL be ht_rd_valid|ht_rd_miss for read, ht_wr_done|ht_wr_collision for write, ht_del_done for delete; unrelated response strobes SHALL be ignored.
REQ-015 Status mapping: read valid -> OK with rsp_value=ht_rd_value; read miss -> MISS with rsp_value=0; wr_done (with or without wr_collision) -> OK; wr_collision without wr_done -> FULL; del_done -> OK.
REQ-016 A wait counter SHALL count cycles spent in WAIT; on reaching TIMEOUT_CYCLES without completion the FSM SHALL go to RESP with status ERROR.
REQ-017 RESP: SHALL pulse rsp_valid for the granted requester for exactly one cycle with rsp_status/rsp_value, then return to IDLE; rsp_value is 0 for non-read ops.
REQ-018 Best-case latency: grant cycle T, table enable T+1, table response T+2, rsp_valid T+3; next grant no earlier than T+4.
REQ-019 busy SHALL be 1 in ISSUE, WAIT, RESP and 0 in IDLE.
REQ-020 req_valid changes while not granted SHALL have no effect; a requester's request SHALL be held valid until its req_ready pulse.

Reset
REQ-021 On rst SHALL force state IDLE, round-robin pointer to the last index (so index 0 is searched first), wait counter 0, and all outputs (req_ready, rsp_valid, rsp_status, rsp_value, busy, ht_*_en, ht_* key/value) to 0.
REQ-022 Reset mid-operation SHALL abandon the operation with no rsp_valid pulse; any late table strobe after reset SHALL be ignored in IDLE.

Structure
REQ-023 Package hash_table_arb_pkg SHALL hold the op encoding, status encoding, and FSM state enum.
REQ-024 Round-robin grant logic SHALL be a sub-module rr_arbiter (NUM_REQ request vector, pointer in, one-hot grant and index out).

Verification
REQ-025 Reset, then req 0 writes key 0x11/value 0xAA, table returns wr_done -> ht_wr_en at T+1, req 0 receives rsp_valid at T+3 with status OK.
REQ-026 All four requesters assert req_valid reads continuously -> grants in order 0,1,2,3,0, each req_ready pulse a one-hot bit.
REQ-027 Req 2 reads key 0x55, table returns rd_miss -> rsp_status MISS, rsp_value 0; table returns rd_valid with 0x1234 -> status OK, rsp_value 0x1234.
REQ-028 Write with wr_collision=1, wr_done=0 -> status FULL; wr_collision=1, wr_done=1 -> status OK.
REQ-029 Table never responds to a delete -> rsp_valid with status ERROR exactly TIMEOUT_CYCLES cycles after WAIT entry; req_op=11 -> ERROR with no ht_*_en pulse.
REQ-030 rst asserted during WAIT, followed by a late ht_rd_valid -> no rsp_valid, busy 0, next grant to index 0.
